// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the instruction ROM and its byte-stream program loader.
package inst_rom_loader_pkg;

    localparam int INST_BUS_W      = 16;
    localparam int INST_ADDR_BUS_W = 16;
    localparam logic [INST_BUS_W-1:0] NOP_INST = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_HI,
        LOAD_LO,
        DONE
    } ld_state_t;

endpackage

// File: rtl/inst_ram_1r1w.sv
// Word array with a synchronous write port and an asynchronous read port.
module inst_ram_1r1w #(
    parameter int DEPTH_LOG2 = 8,
    parameter int WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [0:(1 << DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory for the CPU fetch port, plus a valid/ready byte-stream loader
// that rewrites the memory and holds the CPU in reset while loading.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int ADDR_W     = INST_ADDR_BUS_W,
    parameter int INST_W     = INST_BUS_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_ce_i,
    input  logic [ADDR_W-1:0]     rom_addr_i,
    output logic [INST_W-1:0]     rom_data_o,
    input  logic                  ld_start_i,
    input  logic                  ld_valid_i,
    input  logic [7:0]            ld_data_i,
    input  logic                  ld_last_i,
    output logic                  ld_ready_o,
    output logic                  ld_busy_o,
    output logic                  ld_err_o,
    output logic [DEPTH_LOG2:0]   ld_count_o,
    output logic                  cpu_hold_o
);

    ld_state_t          state, state_nxt;
    logic [DEPTH_LOG2:0] wptr;
    logic [7:0]         hi_byte;
    logic               err;

    logic               accept;
    logic               full;
    logic               we;
    logic               wptr_inc;
    logic               set_err;
    logic               clr;
    logic               hi_ld;
    logic [15:0]        wword;
    logic [INST_W-1:0]  rdata;
    logic               addr_oor;

    assign ld_ready_o = (state == LOAD_HI) || (state == LOAD_LO);
    assign ld_busy_o  = (state != IDLE);
    assign accept     = ld_valid_i && ld_ready_o;
    // wptr saturates at 2**DEPTH_LOG2, so its top bit alone flags a full memory
    assign full       = wptr[DEPTH_LOG2];

    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        wptr_inc  = 1'b0;
        set_err   = 1'b0;
        clr       = 1'b0;
        hi_ld     = 1'b0;
        wword     = {hi_byte, ld_data_i};
        case (state)
            IDLE: begin
                if (ld_start_i) begin
                    clr       = 1'b1;
                    state_nxt = LOAD_HI;
                end
            end
            LOAD_HI: begin
                if (accept) begin
                    hi_ld = 1'b1;
                    if (ld_last_i) begin
                        // odd-length stream: keep the orphan byte as a padded word
                        wword     = {ld_data_i, 8'h00};
                        we        = !full;
                        set_err   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = LOAD_LO;
                    end
                end
            end
            LOAD_LO: begin
                if (accept) begin
                    if (full) begin
                        set_err = 1'b1;
                    end else begin
                        we       = 1'b1;
                        wptr_inc = 1'b1;
                    end
                    state_nxt = ld_last_i ? DONE : LOAD_HI;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wptr    <= '0;
            err     <= 1'b0;
            hi_byte <= '0;
        end else begin
            state <= state_nxt;
            if (clr) begin
                wptr <= '0;
                err  <= 1'b0;
            end else begin
                if (wptr_inc) begin
                    wptr <= wptr + 1'b1;
                end
                if (set_err) begin
                    err <= 1'b1;
                end
            end
            if (hi_ld) begin
                hi_byte <= ld_data_i;
            end
        end
    end

    inst_ram_1r1w #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .WIDTH     (INST_W)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(wptr[DEPTH_LOG2-1:0]),
        .wdata(INST_W'(wword)),
        .raddr(rom_addr_i[DEPTH_LOG2-1:0]),
        .rdata(rdata)
    );

    assign addr_oor   = (rom_addr_i >> DEPTH_LOG2) != '0;
    assign rom_data_o = (rst || !rom_ce_i || addr_oor || ld_busy_o) ? INST_W'(NOP_INST) : rdata;

    assign ld_err_o   = err;
    assign ld_count_o = wptr;
    assign cpu_hold_o = rst || ld_busy_o;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized bench for inst_rom_loader: a 256-word and a 4-word instance share one stimulus stream.
module tb_inst_rom_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce_i;
    logic [15:0] rom_addr_i;
    logic        ld_start_i;
    logic        ld_valid_i;
    logic [7:0]  ld_data_i;
    logic        ld_last_i;

    logic [15:0] rom_data_b, rom_data_s;
    logic        ready_b, ready_s, busy_b, busy_s, err_b, err_s, hold_b, hold_s;
    logic [8:0]  count_b;
    logic [2:0]  count_s;

    int checks   = 0;
    int failures = 0;

    // reference model: index 0 = 256-word instance, index 1 = 4-word instance
    int          depth [2] = '{256, 4};
    logic [15:0] exp_mem [2][256];
    bit          known   [2][256];
    int          exp_cnt [2];
    bit          exp_err [2];

    always #5 clk = ~clk;

    inst_rom_loader #(.DEPTH_LOG2(8)) dut_big (
        .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_b),
        .ld_start_i(ld_start_i), .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i), .ld_last_i(ld_last_i),
        .ld_ready_o(ready_b), .ld_busy_o(busy_b), .ld_err_o(err_b), .ld_count_o(count_b),
        .cpu_hold_o(hold_b)
    );

    inst_rom_loader #(.DEPTH_LOG2(2)) dut_small (
        .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_s),
        .ld_start_i(ld_start_i), .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i), .ld_last_i(ld_last_i),
        .ld_ready_o(ready_s), .ld_busy_o(busy_s), .ld_err_o(err_s), .ld_count_o(count_s),
        .cpu_hold_o(hold_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Whole-stream model: bytes pair into words, odd tail becomes {b,00} with error.
    task automatic model_load(input logic [7:0] q [$]);
        for (int k = 0; k < 2; k++) begin
            int cnt = 0;
            bit err = 0;
            for (int i = 0; i < q.size(); i += 2) begin
                if (i == q.size() - 1) begin
                    err = 1;
                    if (cnt < depth[k]) begin
                        exp_mem[k][cnt] = {q[i], 8'h00};
                        known[k][cnt]   = 1;
                    end
                end else if (cnt < depth[k]) begin
                    exp_mem[k][cnt] = {q[i], q[i+1]};
                    known[k][cnt]   = 1;
                    cnt++;
                end else begin
                    err = 1;
                end
            end
            exp_cnt[k] = cnt;
            exp_err[k] = err;
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        ld_start_i = 1'b1;
        @(negedge clk);
        ld_start_i = 1'b0;
    endtask

    // Presents one byte after `gap` idle cycles; returns at the negedge before the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit last, input int gap, input bit poke_start);
        for (int g = 0; g < gap; g++) begin
            ld_valid_i = 1'b0;
            ld_start_i = poke_start && (g == 0);
            @(negedge clk);
        end
        ld_start_i = 1'b0;
        ld_valid_i = 1'b1;
        ld_data_i  = b;
        ld_last_i  = last;
        #1;
        for (int t = 0; t < 50 && !ready_b; t++) begin
            @(negedge clk);
            #1;
        end
        check_eq("ready_wait", ready_b, 1);
    endtask

    task automatic run_load(input logic [7:0] q [$], input bit gaps, input bit mid_start);
        int mid_idx;
        model_load(q);
        mid_idx = (q.size() >= 2) ? q.size() / 2 : -1;
        start_pulse();
        #1;
        check_eq("start_clr_err", err_b, 0);
        check_eq("start_clr_cnt", count_b, 0);
        for (int i = 0; i < q.size(); i++) begin
            int gap;
            gap = gaps ? $urandom_range(0, 3) : 0;
            if (mid_start && i == mid_idx && gap == 0) gap = 1;
            if (i > 0) @(negedge clk);
            send_byte(q[i], i == q.size() - 1, gap, mid_start && i == mid_idx);
        end
        @(negedge clk);
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
        #1;
        check_eq("done_busy", busy_b, 1);
        check_eq("done_ready", ready_b, 0);
        check_eq("done_hold", hold_b, 1);
        @(negedge clk);
        #1;
        check_eq("post_hold_b", hold_b, 0);
        check_eq("post_hold_s", hold_s, 0);
        check_eq("cnt_b", count_b, exp_cnt[0]);
        check_eq("cnt_s", count_s, exp_cnt[1]);
        check_eq("err_b", err_b, exp_err[0]);
        check_eq("err_s", err_s, exp_err[1]);
    endtask

    task automatic check_fetch(input logic [15:0] a, input bit ce);
        @(negedge clk);
        rom_ce_i   = ce;
        rom_addr_i = a;
        #1;
        for (int k = 0; k < 2; k++) begin
            logic [15:0] got;
            got = (k == 0) ? rom_data_b : rom_data_s;
            if (!ce || a >= depth[k]) begin
                check_eq(k == 0 ? "fetch_nop_b" : "fetch_nop_s", got, 0);
            end else if (known[k][a]) begin
                check_eq(k == 0 ? "fetch_b" : "fetch_s", got, exp_mem[k][a]);
            end
        end
    endtask

    initial begin
        logic [7:0] q [$];

        rst        = 1'b1;
        rom_ce_i   = 1'b1;
        rom_addr_i = '0;
        ld_start_i = 1'b0;
        ld_valid_i = 1'b0;
        ld_data_i  = '0;
        ld_last_i  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_cnt[k] = 0;
            exp_err[k] = 0;
            for (int a = 0; a < 256; a++) known[k][a] = 0;
        end

        // reset behaviour
        repeat (4) @(negedge clk);
        #1;
        check_eq("rst_hold", hold_b, 1);
        check_eq("rst_ready", ready_b, 0);
        check_eq("rst_data", rom_data_b, 0);
        check_eq("rst_busy", busy_b, 0);
        check_eq("rst_cnt", count_b, 0);
        check_eq("rst_err", err_b, 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_eq("idle_hold", hold_b, 0);

        // directed gapless stream
        q = '{8'h34, 8'h44, 8'h12, 8'hC3};
        run_load(q, 0, 0);
        check_fetch(16'd1, 1);
        check_eq("dir_word1", rom_data_b, 16'h12C3);
        check_fetch(16'd0, 1);
        check_eq("dir_word0", rom_data_b, 16'h3444);

        // same stream with gaps and an ignored mid-load start
        for (int k = 0; k < 2; k++) for (int a = 0; a < 2; a++) known[k][a] = 0;
        run_load(q, 1, 1);
        check_fetch(16'd0, 1);
        check_fetch(16'd1, 1);

        // odd-length stream: last on the third byte
        q = '{8'h5A, 8'hA5, 8'hAB};
        run_load(q, 1, 0);
        check_fetch(16'd1, 1);
        check_eq("odd_word1", rom_data_b, 16'hAB00);
        repeat (3) @(negedge clk);
        #1;
        check_eq("err_sticky", err_b, 1);

        // overflow of the 4-word instance
        q = {};
        for (int i = 0; i < 10; i++) q.push_back(8'($urandom_range(0, 255)));
        run_load(q, 1, 0);
        for (int a = 0; a < 6; a++) check_fetch(16'(a), 1);

        // out-of-range and disabled fetches
        check_fetch(16'h0100, 1);
        check_fetch(16'h0004, 1);
        check_fetch(16'h0000, 0);

        // randomized loads
        for (int n = 0; n < 8; n++) begin
            int len;
            len = $urandom_range(1, 14);
            q = {};
            for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
            run_load(q, 1, 1'($urandom_range(0, 1)));
            for (int a = 0; a < 8; a++) check_fetch(16'(a), 1);
            check_fetch(16'($urandom_range(0, 300)), 1'($urandom_range(0, 1)));
        end

        // reset in LOAD_LO keeps already-written words
        start_pulse();
        send_byte(8'h55, 0, 0, 0);
        @(negedge clk);
        send_byte(8'h66, 0, 0, 0);
        @(negedge clk);
        send_byte(8'h77, 0, 0, 0);
        @(negedge clk);
        ld_valid_i = 1'b0;
        rom_ce_i   = 1'b1;
        rom_addr_i = '0;
        #1;
        check_eq("lo_busy", busy_b, 1);
        check_eq("lo_ready", ready_b, 1);
        check_eq("lo_fetch_gated", rom_data_b, 0);
        for (int k = 0; k < 2; k++) begin
            exp_mem[k][0] = 16'h5566;
            known[k][0]   = 1;
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("midrst_busy", busy_b, 0);
        check_eq("midrst_ready", ready_b, 0);
        check_eq("midrst_hold", hold_b, 1);
        @(negedge clk);
        #1;
        check_eq("midrst_hold2", hold_s, 1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_eq("midrst_release", hold_b, 0);
        check_eq("midrst_cnt", count_b, 0);
        check_fetch(16'd0, 1);
        check_fetch(16'd0, 1);
        check_eq("midrst_word0", rom_data_s, 16'h5566);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
